serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor. It computes `a - b - bin` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's parallel adders, for area-constrained datapaths where WIDTH cycles of latency are acceptable. Operands are captured on a start handshake. Results are registered and held until the next operation completes.

---
 rtl/serial_subtractor.sv | 71 +++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, through a single full-subtractor cell.
// Results are registered on completion and held until the next operation finishes.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sa, sb, sd, sd_n;
    logic [CW-1:0] cnt;
    logic br, br_n, bmsb, d, load, last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        load    = start && state != SHIFT;
        last    = cnt == CW'(WIDTH - 1);
        state_n = load ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
        d       = sa[0] ^ sb[0] ^ br;
        br_n    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sd_n    = {d, sd[WIDTH-1:1]};
        busy    = state == SHIFT;
        done    = state == DONE;
        ovf     = bmsb ^ bout;
    end
    // bmsb is the borrow entering the MSB; with bout it yields signed overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sd   <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            bmsb <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b1;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_n;
            br  <= br_n;
            cnt <= last ? cnt : cnt + 1'b1;
            if (last) begin
                bmsb <= br;
                diff <= sd_n;
                bout <= br_n;
                zero <= sd_n == '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for 4- and 8-bit serial subtractors.
module tb_serial_subtractor;
    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4, zero4, ovf4;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8, zero8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, diff8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
    );
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    res_t q4[$], q8[$];
    res_t e4, e8;
    logic [3:0] held4 = '0;
    logic [7:0] held8 = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(int w, int a, int b, int bin);
        res_t r;
        int h = 1 << (w - 1);
        int dd = a - b - bin;
        int sa = a >= h ? a - 2 * h : a;
        int sb = b >= h ? b - 2 * h : b;
        int s = sa - sb - bin;
        r.bout = dd < 0;
        r.diff = 32'(dd & (2 * h - 1));
        r.zero = r.diff == 0;
        r.ovf  = s < -h || s > h - 1;
        return r;
    endfunction

    // scoreboards: results must appear only with done and stay put otherwise
    always @(negedge clk) begin
        if (rst) held4 = '0;
        else if (done4) begin
            if (q4.size() == 0) chk("unexpected_done4", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("diff4", 32'(diff4), e4.diff);
                chk("bout4", 32'(bout4), 32'(e4.bout));
                chk("zero4", 32'(zero4), 32'(e4.zero));
                chk("ovf4", 32'(ovf4), 32'(e4.ovf));
            end
            held4 = diff4;
        end else chk("hold4", 32'(diff4), 32'(held4));
    end

    always @(negedge clk) begin
        if (rst) held8 = '0;
        else if (done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("diff8", 32'(diff8), e8.diff);
                chk("bout8", 32'(bout8), 32'(e8.bout));
                chk("zero8", 32'(zero8), 32'(e8.zero));
                chk("ovf8", 32'(ovf8), 32'(e8.ovf));
            end
            held8 = diff8;
        end else chk("hold8", 32'(diff8), 32'(held8));
    end

    task automatic wait_done4(output time t);
        int k = 0;
        while (!done4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done4) chk("done4_timeout", 0, 1);
        t = $time;
    endtask

    task automatic wait_done8();
        int k = 0;
        while (!done8 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!done8) chk("done8_timeout", 0, 1);
    endtask

    task automatic op4(int a, int b, int bin, bit poke);
        time t;
        @(negedge clk);
        a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = 1'b1;
        q4.push_back(model(4, a, b, bin));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        if (poke) begin
            start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
        end
        wait_done4(t);
    endtask

    task automatic op8(int a, int b, int bin);
        @(negedge clk);
        a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin); start8 = 1'b1;
        q8.push_back(model(8, a, b, bin));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1, t2, t3;
        int seen;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_diff", 32'(diff4), 0);
        chk("rst_bout", 32'(bout4), 0);
        chk("rst_zero", 32'(zero4), 1);
        chk("rst_ovf", 32'(ovf4), 0);
        #20 rst = 1'b0;

        // latency and busy width
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        q4.push_back(model(4, 7, 3, 0));
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            chk("busy_high", 32'(busy4), 1);
            chk("early_done", 32'(done4), 0);
        end
        @(negedge clk);
        chk("latency_done", 32'(done4), 1);
        chk("busy_low", 32'(busy4), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done4), 0);

        op4(3, 5, 0, 0);
        op4(8, 1, 0, 0);
        op4(7, 15, 0, 0);
        op4(5, 5, 0, 0);
        op4(0, 0, 1, 0);
        op4(12, 6, 1, 1);
        op4(1, 9, 0, 1);

        // start held high: back-to-back every WIDTH+1 cycles
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd9; bin4 = 1'b0; start4 = 1'b1;
        q4.push_back(model(4, 2, 9, 0));
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd6; bin4 = 1'b1;
        q4.push_back(model(4, 13, 6, 1));
        wait_done4(t1);
        @(negedge clk);
        a4 = 4'd4; b4 = 4'd4; bin4 = 1'b0;
        q4.push_back(model(4, 4, 4, 0));
        wait_done4(t2);
        chk("period1", 32'(t2 - t1), 50);
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(t3);
        chk("period2", 32'(t3 - t2), 50);

        // async reset during bit 2 aborts the operation
        op4(9, 2, 0, 0);
        @(negedge clk);
        a4 = 4'd11; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy4), 0);
        chk("abort_done", 32'(done4), 0);
        chk("abort_diff", 32'(diff4), 0);
        chk("abort_bout", 32'(bout4), 0);
        chk("abort_zero", 32'(zero4), 1);
        chk("abort_ovf", 32'(ovf4), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) seen++;
        end
        chk("abort_no_done", 32'(seen), 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(a, b, c, 0);

        op8(0, 0, 0);
        op8(0, 0, 1);
        op8(255, 255, 1);
        op8(128, 1, 0);
        op8(127, 255, 0);
        op8(100, 100, 0);
        repeat (300) op8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));

        @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 0);
        chk("q8_drained", 32'(q8.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
